// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DataMemory; port 0 (CPU) is
// favoured for up to MAX_HOLD grants in a row. Define DMEM_ARB_STATS_EN for grant/conflict counters.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              cpu_stall,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_conflict
`endif
);

  localparam logic       PORT0     = 1'b0;
  localparam logic       PORT1     = 1'b1;
  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_SAT  = 4'hF;

  logic              last_q, last_d;
  logic [3:0]        hold_q, hold_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt_any;
  logic              we_sel;

  // Port 0 wins a conflict unless it already held the memory for MAX_HOLD grants.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = (last_q == PORT1) || (hold_q < HOLD_MAX);
      gnt1 = ~gnt0;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign we_sel    = gnt1 ? we1 : we0;
  assign cpu_stall = req0 & ~gnt0;

  always_comb begin
    mem_MemRead   = 1'b0;
    mem_MemWrite  = 1'b0;
    mem_Address   = '0;
    mem_WriteData = '0;
    if (gnt_any && !rst) begin
      mem_MemRead   = ~we_sel;
      mem_MemWrite  = we_sel;
      mem_Address   = gnt1 ? addr1 : addr0;
      mem_WriteData = gnt1 ? wdata1 : wdata0;
    end
  end

  always_comb begin
    last_d = last_q;
    hold_d = '0;
    if (gnt_any) begin
      last_d = gnt1 ? PORT1 : PORT0;
      if (last_d == last_q) hold_d = (hold_q == HOLD_SAT) ? HOLD_SAT : hold_q + 4'd1;
      else                  hold_d = 4'd1;
    end
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_ReadData : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_ReadData : rdata1_q;
  end

  // A read granted while rst is high is dropped by the reset branch below.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together.
    if (rst) begin
      last_q    <= PORT1;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0_q, stat_gnt1_q, stat_conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (gnt0)         stat_gnt0_q     <= stat_gnt0_q + 32'd1;
      if (gnt1)         stat_gnt1_q     <= stat_gnt1_q + 32'd1;
      if (req0 && req1) stat_conflict_q <= stat_conflict_q + 32'd1;
    end
  end

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small RAM behind the memory port, a reference RAM
// and per-port queues of expected read data checked whenever rvalid rises.
module tb_dmem_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, cpu_stall;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_MemRead, mem_MemWrite;
  logic [ADDR_W-1:0] mem_Address;
  logic [DATA_W-1:0] mem_WriteData, mem_ReadData;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]       stat_gnt0, stat_gnt1, stat_conflict;
`endif

  logic [DATA_W-1:0] ram     [64];
  logic [DATA_W-1:0] ref_ram [64];
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .cpu_stall(cpu_stall),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_ReadData(mem_ReadData)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  assign mem_ReadData = ram[mem_Address[7:2]];
  always @(posedge clk) if (mem_MemWrite) ram[mem_Address[7:2]] <= mem_WriteData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid pops the oldest expected read for that port.
  always @(negedge clk) begin
    if (rvalid0) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 32'(rvalid0), 32'd0);
      else                check("rdata0", rdata0, q0.pop_front());
    end
    if (rvalid1) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 32'(rvalid1), 32'd0);
      else                check("rdata1", rdata1, q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, run;
    logic exp1;

    for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0103;
    ram[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) ref_ram[i] = ram[i];
    {req0, req1, we0, we1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset values
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("idle_strobes", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    check("idle_addr", mem_Address, 32'd0);
    check("idle_wdata", mem_WriteData, 32'd0);

    // Port 0 read of 0x10
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    #1;
    check("rd0_gnt0", 32'(gnt0), 32'd1);
    check("rd0_memread", 32'(mem_MemRead), 32'd1);
    check("rd0_memwrite", 32'(mem_MemWrite), 32'd0);
    check("rd0_addr", mem_Address, 32'h10);
    check("rd0_stall", 32'(cpu_stall), 32'd0);
    q0.push_back(ref_ram[4]);
    step();
    req0 = 1'b0;
    check("rd0_rvalid0", 32'(rvalid0), 32'd1);
    check("rd0_rdata0", rdata0, 32'hDEAD_BEEF);
    check("rd0_rvalid1", 32'(rvalid1), 32'd0);

    // Port 1 write of 0x1234 to 0x20
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234;
    #1;
    check("wr1_gnt1", 32'(gnt1), 32'd1);
    check("wr1_gnt0", 32'(gnt0), 32'd0);
    check("wr1_memwrite", 32'(mem_MemWrite), 32'd1);
    check("wr1_memread", 32'(mem_MemRead), 32'd0);
    check("wr1_addr", mem_Address, 32'h20);
    check("wr1_wdata", mem_WriteData, 32'h1234);
    ref_ram[8] = 32'h1234;
    step();
    req1 = 1'b0;
    check("wr1_no_rvalid1", 32'(rvalid1), 32'd0);

    // Read it back through port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    q1.push_back(ref_ram[8]);
    step();
    req1 = 1'b0;
    check("rb1_rvalid1", 32'(rvalid1), 32'd1);
    check("rb1_rdata1", rdata1, 32'h1234);

    // Continuous contention straight after reset: port 0 reads, port 1 writes
    rst = 1'b1;
    step();
    rst = 1'b0;
    i0 = 0; i1 = 0; run = 0;
    for (int k = 0; k < 10; k++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40 + 32'(4 * i0);
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80 + 32'(4 * i1);
      wdata1 = 32'hA500_0000 | 32'(i1);
      #1;
      exp1 = (run == MAX_HOLD);
      check($sformatf("cont%0d_gnt0", k), 32'(gnt0), 32'(!exp1));
      check($sformatf("cont%0d_gnt1", k), 32'(gnt1), 32'(exp1));
      check($sformatf("cont%0d_stall", k), 32'(cpu_stall), 32'(exp1));
      check($sformatf("cont%0d_memwrite", k), 32'(mem_MemWrite), 32'(exp1));
      check($sformatf("cont%0d_addr", k), mem_Address, exp1 ? addr1 : addr0);
      if (exp1) begin
        check($sformatf("cont%0d_wdata", k), mem_WriteData, wdata1);
        ref_ram[32 + i1] = wdata1;
        i1++;
        run = 0;
      end else begin
        q0.push_back(ref_ram[16 + i0]);
        i0++;
        run++;
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    check("stat_conflict", stat_conflict, 32'd10);
    check("stat_gnt1", stat_gnt1, 32'd2);
    check("stat_gnt_sum", stat_gnt0 + stat_gnt1, 32'd10);
`endif

    // Read back the first contended write through port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80;
    q1.push_back(ref_ram[32]);
    step();
    req1 = 1'b0;

    // Long solo run on port 0 saturates hold; a new port-1 request wins at once
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("solo%0d_gnt0", k), 32'(gnt0), 32'd1);
      q0.push_back(ref_ram[4]);
      step();
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h84;
    #1;
    check("sat_gnt1", 32'(gnt1), 32'd1);
    check("sat_stall", 32'(cpu_stall), 32'd1);
    q1.push_back(ref_ram[33]);
    step();
    req1 = 1'b0;
    #1;
    check("sat_gnt0_after", 32'(gnt0), 32'd1);
    q0.push_back(ref_ram[4]);
    step();
    req0 = 1'b0;

    // An idle cycle clears hold, so port 0 wins the next conflict again
    req0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      q0.push_back(ref_ram[4]);
      step();
    end
    req0 = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    #1;
    check("idle_clear_gnt0", 32'(gnt0), 32'd1);
    q0.push_back(ref_ram[4]);
    step();
    req0 = 1'b0;
    #1;
    check("idle_clear_gnt1", 32'(gnt1), 32'd1);
    q1.push_back(ref_ram[8]);
    step();
    req1 = 1'b0;

    // Reset in the same cycle as a granted read and a pending write
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h0000_0BAD;
    rst = 1'b1;
    #1;
    check("rstmid_memwrite", 32'(mem_MemWrite), 32'd0);
    check("rstmid_memread", 32'(mem_MemRead), 32'd0);
    step();
    rst = 1'b0;
    check("rstmid_rvalid0", 32'(rvalid0), 32'd0);
    check("rstmid_ram_kept", ram[12], ref_ram[12]);
    #1;
    check("rstmid_next_gnt0", 32'(gnt0), 32'd1);
    check("rstmid_next_gnt1", 32'(gnt1), 32'd0);
    q0.push_back(ref_ram[4]);
    step();
    req0 = 1'b0;
    #1;
    check("rstmid_wr_gnt1", 32'(gnt1), 32'd1);
    check("rstmid_wr_memwrite", 32'(mem_MemWrite), 32'd1);
    ref_ram[12] = 32'h0000_0BAD;
    step();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
    q0.push_back(ref_ram[12]);
    step();
    req0 = 1'b0;

    step();
    step();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter sharing the single-port DataMemory between the CPU load/store path (port 0) and a secondary requester such as a program loader or debug master (port 1). It accepts at most one access per cycle and drives the memory control/address/data lines. It returns read data one cycle later with a valid strobe. It also produces a stall signal the CPU uses to hold its PC while port 0 is waiting.

## Interface
- DATA_W, 32, data width
- ADDR_W, 32, address width
- MAX_HOLD, 4, maximum consecutive grants to one port while the other is requesting (1..15)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- addr0 / addr1  in  ADDR_W  byte address; valid with req
- wdata0 / wdata1  in  DATA_W  write data; valid with req
- gnt0 / gnt1  out  1  combinational; access performed this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata0 / rdata1  out  DATA_W  registered read data
- cpu_stall  out  1  combinational; = req0 & ~gnt0
- mem_MemRead / mem_MemWrite  out  1  to DataMemory
- mem_Address  out  ADDR_W  to DataMemory
- mem_WriteData  out  DATA_W  to DataMemory
- mem_ReadData  in  DATA_W  from DataMemory (combinational read)

## Operation
- State is held in three registers:
  - last: the last granted port, 1 bit.
  - hold_cnt: 4 bits.
  - per-port read-return registers.
- Grant decision is combinational each cycle:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port ≠ last is granted. Exception: if last is port 0 and hold_cnt < MAX_HOLD, port 0 keeps priority. This favours the CPU without starving port 1.
  - No request: no grant. Memory strobes are 0, and mem_Address/mem_WriteData are 0.
- Memory drive:
  - Only the granted port's addr/wdata are muxed onto the memory outputs.
  - mem_MemWrite = gnt & we.
  - mem_MemRead = gnt & ~we.
  - mem_MemRead and mem_MemWrite are never both 1.
- State update on each grant:
  - last ← granted port.
  - hold_cnt ← hold_cnt + 1 (saturating at 15) if granted port = previous last; otherwise hold_cnt ← 1.
  - hold_cnt ← 0 on a cycle with no grant.
- Read return: on a granted read, rdataN ← mem_ReadData and rvalidN ← 1 at the next edge. Otherwise rvalidN ← 0; rdataN holds its value.
- Writes return nothing. A write is complete at the edge that ends the grant cycle.

## Timing
- Reset values: last = 1 (so port 0 wins the first conflict), hold_cnt = 0, rvalid0/1 = 0, rdata0/1 = 0.
- Combinational outputs (gnt, cpu_stall, mem_*) follow the inputs, with zero strobes while rst is high.
- Grant latency is 0 cycles from req for an idle or uncontended port.
- Read data latency is 1 cycle after gnt.
- Throughput is 1 access per cycle, including back-to-back accesses from one port.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt high.
  - Deasserting req before gnt is a withdrawal with no side effect.
- Worst-case wait for port 1 under continuous contention is MAX_HOLD cycles. Port 0 waits at most 1 cycle.
- Reset mid-operation:
  - A read granted in the cycle rst is sampled high does not produce rvalid.
  - A write granted in that cycle is blocked, because strobes are forced to 0 during rst.

## Configuration
- DMEM_ARB_STATS_EN defined adds three outputs:
  - stat_gnt0 (32 bit): wrapping count of grants to port 0.
  - stat_gnt1 (32 bit): wrapping count of grants to port 1.
  - stat_conflict (32 bit): wrapping count of cycles with req0 & req1.
- All three counters clear on rst.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Reset, then req0 read addr 0x10 with mem returning 0xDEADBEEF:
  - gnt0 = 1 and mem_MemRead = 1 in the same cycle.
  - Next cycle: rvalid0 = 1, rdata0 = 0xDEADBEEF, rvalid1 = 0.
- req1 write addr 0x20 data 0x1234 alone:
  - gnt1 = 1, mem_MemWrite = 1, mem_Address = 0x20, mem_WriteData = 0x1234.
  - No rvalid afterwards.
- req0 and req1 held continuously with MAX_HOLD = 4:
  - Grant sequence is 0,0,0,0,1,0,0,0,0,1,…
  - cpu_stall = 1 exactly on the port-1 cycles.
- Simultaneous first request after reset: gnt0 wins. Port 1 is granted by cycle MAX_HOLD+1 at the latest.
- Assert rst in the same cycle as a granted read (port 0) and a pending write (port 1):
  - No memory write occurs.
  - rvalid0 = 0 next cycle.
  - hold_cnt = 0; next contention is won by port 0.
- With DMEM_ARB_STATS_EN, run 10 contended cycles:
  - stat_conflict = 10.
  - stat_gnt0 + stat_gnt1 = 10, with stat_gnt1 = 2 for MAX_HOLD = 4.
